// File: rtl/max_pool_2x2_pkg.sv
// ============================================================================
// max_pool_2x2_pkg : shared constants and arithmetic helpers for the pooler
// Rev 1.0
// ============================================================================
`default_nettype none

package max_pool_2x2_pkg;

  localparam int c_DATA_W_DEF    = 16;
  localparam int c_FRAC_BITS_DEF = 8;
  // Working width for compares; must exceed DATA_W so the ceiling never wraps.
  localparam int c_CALC_W        = 32;

  typedef logic signed [c_CALC_W-1:0] calc_t;

  function automatic calc_t relu6_ceil(input int frac_bits);
    return calc_t'(6) << frac_bits;
  endfunction

  localparam calc_t c_RELU6_CEIL_DEF = relu6_ceil(c_FRAC_BITS_DEF);

  function automatic calc_t smax(input calc_t a, input calc_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic calc_t relu6(input calc_t v, input calc_t ceil);
    calc_t r;
    r = v;
    if (v < 0)
      r = '0;
    else if (v > ceil)
      r = ceil;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/max_pool_2x2_line_buf.sv
// ============================================================================
// pool_line_buf : register file holding the pair maxima of the even row
// Rev 1.0
// ============================================================================
`default_nettype none

module pool_line_buf
  import max_pool_2x2_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF,
  parameter int DEPTH  = 2,
  parameter int AW     = 1
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]            rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  // No reset: every entry is rewritten on the even row before the odd row reads it.
  logic signed [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      r_mem[wr_addr] <= wr_data;
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/max_pool_2x2.sv
// ============================================================================
// max_pool_2x2 : non-stalling 2x2/stride-2 max pool with optional ReLU6 clamp
// Rev 1.0
// ============================================================================
`default_nettype none

module max_pool_2x2
  import max_pool_2x2_pkg::*;
#(
  parameter int DATA_W    = c_DATA_W_DEF,
  parameter int FMAP_W    = 4,
  parameter int FMAP_H    = 4,
  parameter int RELU_EN   = 1,
  parameter int FRAC_BITS = c_FRAC_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     frame_done
);

  localparam int c_COL_W    = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
  localparam int c_ROW_W    = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
  localparam int c_LB_DEPTH = (FMAP_W / 2 > 0) ? FMAP_W / 2 : 1;
  localparam int c_LB_AW    = (c_LB_DEPTH > 1) ? $clog2(c_LB_DEPTH) : 1;
  localparam bit c_DEGEN    = (FMAP_W < 2) || (FMAP_H < 2);

  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(FMAP_W - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(FMAP_H - 1);

  logic [c_COL_W-1:0]       r_col;
  logic [c_ROW_W-1:0]       r_row;
  logic signed [DATA_W-1:0] r_hold;
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_frame_done;

  logic                     w_run;
  logic                     w_col_odd;
  logic                     w_row_odd;
  logic                     w_col_wrap;
  logic                     w_row_wrap;
  logic                     w_emit;
  logic                     w_lb_wr;
  logic [c_LB_AW-1:0]       w_lb_addr;
  logic signed [DATA_W-1:0] w_lb_rd;
  calc_t                    w_hold_x;
  calc_t                    w_in_x;
  calc_t                    w_lb_x;
  calc_t                    w_pair_max;
  calc_t                    w_win_max;
  calc_t                    w_pooled;
  logic                     w_fd_next;

  assign w_run      = rst_n && !clr;
  assign w_col_odd  = r_col[0];
  assign w_row_odd  = r_row[0];
  assign w_col_wrap = (r_col == c_COL_LAST);
  assign w_row_wrap = (r_row == c_ROW_LAST);

  // Odd row/col parity alone selects windows: a trailing odd column or row
  // always has an even index, so it never completes a window.
  assign w_emit  = in_valid && w_col_odd && w_row_odd;
  assign w_lb_wr = w_run && in_valid && w_col_odd && !w_row_odd;

  assign w_lb_addr = c_LB_AW'(r_col >> 1);

  assign w_hold_x   = calc_t'(r_hold);
  assign w_in_x     = calc_t'(in_data);
  assign w_lb_x     = calc_t'(w_lb_rd);
  assign w_pair_max = smax(w_hold_x, w_in_x);
  assign w_win_max  = smax(w_pair_max, w_lb_x);

  generate
    if (RELU_EN != 0) begin : g_relu
      localparam calc_t c_CEIL = relu6_ceil(FRAC_BITS);
      assign w_pooled = relu6(w_win_max, c_CEIL);
    end else begin : g_pass
      assign w_pooled = w_win_max;
    end
  endgenerate

  generate
    if (c_DEGEN) begin : g_fd_degen
      // No window can complete, so mark the end of the input frame instead.
      assign w_fd_next = in_valid && w_col_wrap && w_row_wrap;
    end else begin : g_fd_pool
      localparam logic [c_COL_W-1:0] c_COL_POOL_LAST = c_COL_W'(2 * (FMAP_W / 2) - 1);
      localparam logic [c_ROW_W-1:0] c_ROW_POOL_LAST = c_ROW_W'(2 * (FMAP_H / 2) - 1);
      assign w_fd_next = w_emit && (r_col == c_COL_POOL_LAST) && (r_row == c_ROW_POOL_LAST);
    end
  endgenerate

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (c_LB_DEPTH),
    .AW     (c_LB_AW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (w_lb_wr),
    .wr_addr (w_lb_addr),
    .wr_data (DATA_W'(w_pair_max)),
    .rd_addr (w_lb_addr),
    .rd_data (w_lb_rd)
  );

  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_col        <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= w_emit;
      r_frame_done <= w_fd_next;
      if (w_emit)
        r_out_data <= DATA_W'(w_pooled);
      if (in_valid) begin
        if (!w_col_odd)
          r_hold <= in_data;
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= w_row_wrap ? '0 : r_row + c_ROW_W'(1);
        end else begin
          r_col <= r_col + c_COL_W'(1);
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_max_pool_2x2.sv
// ============================================================================
// tb_max_pool_2x2 : scoreboard bench for 4x4 (raw and ReLU6) and 3x3 poolers
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_max_pool_2x2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid_a, in_valid_b;
  logic [15:0] in_data_a, in_data_b;
  logic        ov_raw, ov_relu, ov_3x3;
  logic [15:0] od_raw, od_relu, od_3x3;
  logic        fd_raw, fd_relu, fd_3x3;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] q_raw[$];
  logic [16:0] q_relu[$];
  logic [16:0] q_3x3[$];

  int frm_a[16];
  int frm_b[9];
  int idx_a = 0;
  int idx_b = 0;

  always #5 clk = ~clk;

  max_pool_2x2 #(.DATA_W(16), .FMAP_W(4), .FMAP_H(4), .RELU_EN(0), .FRAC_BITS(8)) u_dut_raw (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid_a), .in_data(in_data_a),
    .out_valid(ov_raw), .out_data(od_raw), .frame_done(fd_raw));

  max_pool_2x2 #(.DATA_W(16), .FMAP_W(4), .FMAP_H(4), .RELU_EN(1), .FRAC_BITS(8)) u_dut_relu (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid_a), .in_data(in_data_a),
    .out_valid(ov_relu), .out_data(od_relu), .frame_done(fd_relu));

  max_pool_2x2 #(.DATA_W(16), .FMAP_W(3), .FMAP_H(3), .RELU_EN(0), .FRAC_BITS(8)) u_dut_3x3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid_b), .in_data(in_data_b),
    .out_valid(ov_3x3), .out_data(od_3x3), .frame_done(fd_3x3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int relu6_ref(input int v);
    if (v < 0) return 0;
    if (v > 1536) return 1536;
    return v;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic score(input string tag, input logic ov, input logic [15:0] od, input logic fd,
                       ref logic [16:0] q[$]);
    logic [16:0] e;
    if (ov) begin
      if (q.size() == 0) begin
        check({tag, "_extra"}, ov, 1'b0);
      end else begin
        e = q.pop_front();
        check({tag, "_data"}, od, e[15:0]);
        check({tag, "_done"}, fd, e[16]);
      end
    end else if (fd) begin
      check({tag, "_done_alone"}, fd, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    score("raw",  ov_raw,  od_raw,  fd_raw,  q_raw);
    score("relu", ov_relu, od_relu, fd_relu, q_relu);
    score("3x3",  ov_3x3,  od_3x3,  fd_3x3,  q_3x3);
  end

  // 4x4 stream: expectations come straight from the 2x2 window definition.
  task automatic word_a(input int v);
    int r, c, m;
    in_valid_a = 1'b1;
    in_data_a  = 16'(v);
    frm_a[idx_a] = v;
    r = idx_a / 4;
    c = idx_a % 4;
    if (r % 2 == 1 && c % 2 == 1) begin
      m = max4(frm_a[idx_a], frm_a[idx_a-1], frm_a[idx_a-4], frm_a[idx_a-5]);
      q_raw.push_back({idx_a == 15, 16'(m)});
      q_relu.push_back({idx_a == 15, 16'(relu6_ref(m))});
    end
    idx_a = (idx_a == 15) ? 0 : idx_a + 1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
  endtask

  // 3x3 stream: only the top-left window exists; col 2 and row 2 are dropped.
  task automatic word_b(input int v);
    int r, c, m;
    in_valid_b = 1'b1;
    in_data_b  = 16'(v);
    frm_b[idx_b] = v;
    r = idx_b / 3;
    c = idx_b % 3;
    if (r == 1 && c == 1) begin
      m = max4(frm_b[idx_b], frm_b[idx_b-1], frm_b[idx_b-3], frm_b[idx_b-4]);
      q_3x3.push_back({1'b1, 16'(m)});
    end
    idx_b = (idx_b == 8) ? 0 : idx_b + 1;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset(input bit use_clr);
    if (use_clr) clr = 1'b1;
    else rst_n = 1'b0;
    in_valid_a = 1'b1; in_data_a = 16'h7fff;
    in_valid_b = 1'b1; in_data_b = 16'h7fff;
    @(posedge clk); #1;
    clr = 1'b0; rst_n = 1'b1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    idx_a = 0; idx_b = 0;
    check("rst_raw_valid", ov_raw, 1'b0);
    check("rst_raw_data", od_raw, 16'h0);
    check("rst_raw_done", fd_raw, 1'b0);
    check("rst_relu_data", od_relu, 16'h0);
    check("rst_3x3_valid", ov_3x3, 1'b0);
    check("rst_3x3_data", od_3x3, 16'h0);
  endtask

  initial begin
    int neg_frame[8];
    neg_frame = '{-3, -1, 256, 2048, -8, -2, -5, 768};
    rst_n = 1'b0; clr = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_data_a = '0; in_data_b = '0;
    idle(2);
    pulse_reset(1'b0);

    // 3x3 with two idle cycles per row: inputs 1..9 -> single 5
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) word_b(3 * r + c + 1);
      idle(2);
    end
    for (int i = 0; i < 9; i++) begin
      word_b(int'($urandom_range(0, 4000)) - 2000);
      idle(int'($urandom_range(0, 3)));
    end
    idle(2);

    // basic ramp 0..15 -> 5,7,13,15
    for (int i = 0; i < 16; i++) word_a(i);
    idle(2);

    // reset mid-frame, out_data was 105 beforehand
    for (int i = 0; i < 7; i++) word_a(100 + i);
    pulse_reset(1'b0);
    for (int i = 0; i < 16; i++) word_a(i);
    idle(2);

    // negatives and ReLU6 ceiling
    for (int i = 0; i < 8; i++) word_a(neg_frame[i]);
    for (int i = 0; i < 8; i++) word_a(int'($urandom_range(0, 6000)) - 3000);
    idle(2);

    // back-to-back frames, second must not see first's line buffer
    for (int i = 0; i < 16; i++) word_a(int'($urandom_range(1000, 2000)));
    for (int i = 0; i < 16; i++) word_a(-int'($urandom_range(1000, 2000)));
    idle(2);

    // clr after 6 words, then a clean frame
    for (int i = 0; i < 6; i++) word_a(200 + i);
    pulse_reset(1'b1);
    for (int i = 0; i < 16; i++) word_a(i);
    idle(4);

    check("raw_pending", q_raw.size(), 0);
    check("relu_pending", q_relu.size(), 0);
    check("3x3_pending", q_3x3.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
